// File: rtl/adc_pkg.sv
// Shared definitions for the ADC ring writer: state encoding, bus widths and
// default RAM placement of the EMG/ECG rings.
package adc_pkg;

  localparam int ADC_SAMPLE_W = 16;
  localparam int RAM_ADDR_W   = 12;
  localparam int RAM_DATA_W   = 32;
  localparam int IDX_W        = 10;

  localparam logic [RAM_ADDR_W-1:0] DEFAULT_EMG_BASE = 12'hC7F;
  localparam logic [RAM_ADDR_W-1:0] DEFAULT_ECG_BASE = 12'h801;
  localparam int                    DEFAULT_DEPTH    = 640;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    WR_EMG = 2'd2,
    WR_ECG = 2'd3
  } adc_state_t;

  // Ring slot address; wraps modulo the 12-bit RAM address space.
  function automatic logic [RAM_ADDR_W-1:0] ring_addr(
    input logic [RAM_ADDR_W-1:0] base,
    input logic [IDX_W-1:0]      idx
  );
    return base + RAM_ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Sample tick generator: free-running 0..TICK_CYCLES-1 counter while enabled,
// one-cycle tick on the terminal count.
module adc_tick_gen #(
  parameter int TICK_CYCLES = 175000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/adc_ring_writer.sv
// Averages EMG/ECG samples over 2^AVG_LOG2 ticks and writes each averaged pair
// into per-channel RAM rings (EMG then ECG on consecutive cycles).
module adc_ring_writer
  import adc_pkg::*;
#(
  parameter int                    TICK_CYCLES = 175000,
  parameter int                    AVG_LOG2    = 0,
  parameter int                    DEPTH       = DEFAULT_DEPTH,
  parameter logic [RAM_ADDR_W-1:0] EMG_BASE    = DEFAULT_EMG_BASE,
  parameter logic [RAM_ADDR_W-1:0] ECG_BASE    = DEFAULT_ECG_BASE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [31:0]           emg_in,
  input  logic [31:0]           ecg_in,
  output logic                  adc_wEn,
  output logic [RAM_ADDR_W-1:0] adc_addr,
  output logic [RAM_DATA_W-1:0] adc_dataIn,
  output logic [IDX_W-1:0]      emg_wr_idx,
  output logic [IDX_W-1:0]      ecg_wr_idx,
  output logic                  frame_done
);

  localparam int ACC_W = ADC_SAMPLE_W + AVG_LOG2;
  localparam int SUB_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'((1 << AVG_LOG2) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  function automatic logic [ADC_SAMPLE_W-1:0] box_avg(input logic [ACC_W-1:0] sum);
    return ADC_SAMPLE_W'(sum >> AVG_LOG2);
  endfunction

  adc_state_t state_q, state_d;

  logic                    tick;
  logic [ACC_W-1:0]        emg_acc, ecg_acc;
  logic [ACC_W-1:0]        emg_sum, ecg_sum;
  logic [SUB_W-1:0]        sub_cnt;
  logic [ADC_SAMPLE_W-1:0] ecg_avg;
  logic                    pair_done;
  logic                    unused_hi;

  assign unused_hi = ^{emg_in[31:ADC_SAMPLE_W], ecg_in[31:ADC_SAMPLE_W]};

  // Counter is held at zero whenever acquisition is off.
  adc_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (enable),
    .clear  (!enable),
    .tick   (tick)
  );

  assign emg_sum   = emg_acc + ACC_W'(emg_in[ADC_SAMPLE_W-1:0]);
  assign ecg_sum   = ecg_acc + ACC_W'(ecg_in[ADC_SAMPLE_W-1:0]);
  assign pair_done = (state_q == ACC) && enable && tick && (sub_cnt == SUB_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ACC;
      ACC: begin
        if (!enable)        state_d = IDLE;
        else if (pair_done) state_d = WR_EMG;
      end
      // Once the EMG half is out, the ECG half always follows.
      WR_EMG:  state_d = WR_ECG;
      WR_ECG:  state_d = enable ? ACC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      emg_acc    <= '0;
      ecg_acc    <= '0;
      sub_cnt    <= '0;
      ecg_avg    <= '0;
      adc_wEn    <= 1'b0;
      adc_addr   <= '0;
      adc_dataIn <= '0;
      emg_wr_idx <= '0;
      ecg_wr_idx <= '0;
      frame_done <= 1'b0;
    end else begin
      adc_wEn    <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        ACC: begin
          if (!enable) begin
            emg_acc <= '0;
            ecg_acc <= '0;
            sub_cnt <= '0;
          end else if (pair_done) begin
            emg_acc    <= '0;
            ecg_acc    <= '0;
            sub_cnt    <= '0;
            ecg_avg    <= box_avg(ecg_sum);
            adc_wEn    <= 1'b1;
            adc_addr   <= ring_addr(EMG_BASE, emg_wr_idx);
            adc_dataIn <= RAM_DATA_W'(box_avg(emg_sum));
          end else if (tick) begin
            emg_acc <= emg_sum;
            ecg_acc <= ecg_sum;
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
        WR_EMG: begin
          adc_wEn    <= 1'b1;
          adc_addr   <= ring_addr(ECG_BASE, ecg_wr_idx);
          adc_dataIn <= RAM_DATA_W'(ecg_avg);
        end
        WR_ECG: begin
          // Both rings advance together so the indices never diverge.
          if (ecg_wr_idx == IDX_LAST) begin
            emg_wr_idx <= '0;
            ecg_wr_idx <= '0;
            frame_done <= 1'b1;
          end else begin
            emg_wr_idx <= ecg_wr_idx + 1'b1;
            ecg_wr_idx <= ecg_wr_idx + 1'b1;
          end
        end
        default: begin
          emg_acc <= '0;
          ecg_acc <= '0;
          sub_cnt <= '0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  tick_not_in_write: assert property (
    @(posedge clock) disable iff (!reset_n)
    ((state_q == WR_EMG) || (state_q == WR_ECG)) |-> !tick
  );
`endif

endmodule

// File: tb/tb_adc_ring_writer.sv
// Directed bench for adc_ring_writer: one unaveraged DEPTH=4 instance near the
// top of the address space and one 4-tick averaging instance.
module tb_adc_ring_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable0, enable1;
  logic [31:0] emg_in, ecg_in;

  logic        wen0, wen1;
  logic [11:0] addr0, addr1;
  logic [31:0] data0, data1;
  logic [9:0]  emg_idx0, ecg_idx0, emg_idx1, ecg_idx1;
  logic        fd0, fd1;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  adc_ring_writer #(
    .TICK_CYCLES(10), .AVG_LOG2(0), .DEPTH(4),
    .EMG_BASE(12'hFFE), .ECG_BASE(12'h801)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .enable(enable0),
    .emg_in(emg_in), .ecg_in(ecg_in),
    .adc_wEn(wen0), .adc_addr(addr0), .adc_dataIn(data0),
    .emg_wr_idx(emg_idx0), .ecg_wr_idx(ecg_idx0), .frame_done(fd0)
  );

  adc_ring_writer #(
    .TICK_CYCLES(10), .AVG_LOG2(2), .DEPTH(640),
    .EMG_BASE(12'hC7F), .ECG_BASE(12'h801)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable1),
    .emg_in(emg_in), .ecg_in(ecg_in),
    .adc_wEn(wen1), .adc_addr(addr1), .adc_dataIn(data1),
    .emg_wr_idx(emg_idx1), .ecg_wr_idx(ecg_idx1), .frame_done(fd1)
  );

  // Step negedges until the selected instance strobes or the budget runs out.
  task automatic wait_wen(input bit which, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (((which ? wen1 : wen0) !== 1'b1) && (n < limit));
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    enable0 = 1'b1;
    enable1 = 1'b1;
    emg_in  = $urandom;
    ecg_in  = $urandom;
    #1 reset_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      emg_in = $urandom;
      ecg_in = $urandom;
      vectors++;
      if ({wen0, wen1, fd0, fd1} !== 4'b0 || emg_idx0 !== 10'd0 || ecg_idx0 !== 10'd0 ||
          emg_idx1 !== 10'd0 || ecg_idx1 !== 10'd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: wEn=%b/%b fd=%b/%b idx=%0d,%0d,%0d,%0d required all zero",
                 i, wen0, wen1, fd0, fd1, emg_idx0, ecg_idx0, emg_idx1, ecg_idx1);
      end
    end
    emg_in  = 32'hABCD_0123;
    ecg_in  = 32'h5555_0456;
    enable1 = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_basic_pair();
    int n;
    wait_wen(1'b0, 40, n);
    vectors++;
    if (wen0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_timeout: wEn=%b after %0d cycles, required 1", wen0, n);
    end
    vectors++;
    if (addr0 !== 12'hFFE || data0 !== 32'h0000_0123) begin
      errors++;
      $display("FAIL basic_emg: addr=%h data=%h required FFE 00000123", addr0, data0);
    end
    @(negedge clock);
    vectors++;
    if (wen0 !== 1'b1 || addr0 !== 12'h801 || data0 !== 32'h0000_0456) begin
      errors++;
      $display("FAIL basic_ecg: wEn=%b addr=%h data=%h required 1 801 00000456", wen0, addr0, data0);
    end
    @(negedge clock);
    vectors++;
    if (wen0 !== 1'b0 || emg_idx0 !== 10'd1 || ecg_idx0 !== 10'd1 || fd0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: wEn=%b idx=%0d/%0d fd=%b required 0 1/1 0", wen0, emg_idx0, ecg_idx0, fd0);
    end
  endtask

  task automatic test_wrap_modulo();
    int          n;
    int          exp_gap;
    logic [15:0] ev, cv;
    logic [11:0] exp_emg, exp_ecg;
    logic [9:0]  exp_idx;
    for (int p = 2; p <= 5; p++) begin
      ev = 16'h0100 + 16'(p);
      cv = 16'h0400 + 16'(p);
      emg_in  = {16'hFFFF, ev};
      ecg_in  = {16'h1234, cv};
      exp_gap = (p == 5) ? 7 : 8;
      exp_emg = 12'hFFE + 12'((p - 1) % 4);
      exp_ecg = 12'h801 + 12'((p - 1) % 4);
      exp_idx = 10'(p % 4);
      wait_wen(1'b0, 40, n);
      vectors++;
      if (wen0 !== 1'b1 || n != exp_gap) begin
        errors++;
        $display("FAIL wrap_gap pair %0d: wEn=%b after %0d cycles, required 1 after %0d", p, wen0, n, exp_gap);
      end
      vectors++;
      if (addr0 !== exp_emg || data0 !== {16'h0, ev}) begin
        errors++;
        $display("FAIL wrap_emg pair %0d: addr=%h data=%h required %h %h", p, addr0, data0, exp_emg, {16'h0, ev});
      end
      @(negedge clock);
      vectors++;
      if (wen0 !== 1'b1 || addr0 !== exp_ecg || data0 !== {16'h0, cv}) begin
        errors++;
        $display("FAIL wrap_ecg pair %0d: wEn=%b addr=%h data=%h required 1 %h %h", p, wen0, addr0, data0, exp_ecg, {16'h0, cv});
      end
      @(negedge clock);
      vectors++;
      if (wen0 !== 1'b0 || emg_idx0 !== exp_idx || ecg_idx0 !== exp_idx || fd0 !== (p == 4)) begin
        errors++;
        $display("FAIL wrap_after pair %0d: wEn=%b idx=%0d/%0d fd=%b required 0 %0d/%0d %b",
                 p, wen0, emg_idx0, ecg_idx0, fd0, exp_idx, exp_idx, (p == 4));
      end
      if (p == 4) begin
        @(negedge clock);
        vectors++;
        if (fd0 !== 1'b0) begin
          errors++;
          $display("FAIL wrap_pulse_width: frame_done=%b one cycle later, required 0", fd0);
        end
      end
    end
  endtask

  task automatic test_averaging();
    int n;
    enable0 = 1'b0;
    enable1 = 1'b1;
    emg_in = 32'h0000_FFFF; ecg_in = 32'h0000_0001;
    repeat (15) @(negedge clock);
    emg_in = 32'h0000_FFFF; ecg_in = 32'h0000_0002;
    repeat (10) @(negedge clock);
    emg_in = 32'h0000_0001; ecg_in = 32'h0000_0003;
    repeat (10) @(negedge clock);
    emg_in = 32'h0000_0003; ecg_in = 32'h0000_0004;
    wait_wen(1'b1, 20, n);
    vectors++;
    if (wen1 !== 1'b1 || n != 5) begin
      errors++;
      $display("FAIL avg_latency: wEn=%b after %0d cycles, required 1 after 5", wen1, n);
    end
    vectors++;
    if (addr1 !== 12'hC7F || data1 !== 32'h0000_8000) begin
      errors++;
      $display("FAIL avg_emg: addr=%h data=%h required C7F 00008000", addr1, data1);
    end
    emg_in = 32'h0000_0004; ecg_in = 32'h0000_0008;
    @(negedge clock);
    vectors++;
    if (wen1 !== 1'b1 || addr1 !== 12'h801 || data1 !== 32'h0000_0002) begin
      errors++;
      $display("FAIL avg_ecg: wEn=%b addr=%h data=%h required 1 801 00000002", wen1, addr1, data1);
    end
    @(negedge clock);
    wait_wen(1'b1, 60, n);
    vectors++;
    if (wen1 !== 1'b1 || n != 38) begin
      errors++;
      $display("FAIL avg_pair_spacing: wEn=%b after %0d cycles, required 1 after 38", wen1, n);
    end
    vectors++;
    if (addr1 !== 12'hC80 || data1 !== 32'h0000_0004) begin
      errors++;
      $display("FAIL avg_emg2: addr=%h data=%h required C80 00000004", addr1, data1);
    end
    @(negedge clock);
    vectors++;
    if (wen1 !== 1'b1 || addr1 !== 12'h802 || data1 !== 32'h0000_0008) begin
      errors++;
      $display("FAIL avg_ecg2: wEn=%b addr=%h data=%h required 1 802 00000008", wen1, addr1, data1);
    end
    @(negedge clock);
  endtask

  task automatic test_enable_drop();
    int n;
    int writes;
    // Two ticks of full-scale input, then abandon the partial sum.
    emg_in = 32'h0000_FFFF; ecg_in = 32'h0000_FFFF;
    writes = 0;
    repeat (25) begin
      @(negedge clock);
      if (wen1 === 1'b1) writes++;
    end
    enable1 = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (wen1 === 1'b1) writes++;
    end
    vectors++;
    if (writes != 0) begin
      errors++;
      $display("FAIL drop_acc_nowrite: %0d writes seen, required 0", writes);
    end
    emg_in = 32'h0000_0010; ecg_in = 32'h0000_0020;
    enable1 = 1'b1;
    wait_wen(1'b1, 60, n);
    vectors++;
    if (wen1 !== 1'b1 || n != 40 || addr1 !== 12'hC81 || data1 !== 32'h0000_0010) begin
      errors++;
      $display("FAIL drop_acc_fresh: wEn=%b n=%0d addr=%h data=%h required 1 40 C81 00000010", wen1, n, addr1, data1);
    end
    @(negedge clock);
    vectors++;
    if (wen1 !== 1'b1 || addr1 !== 12'h803 || data1 !== 32'h0000_0020) begin
      errors++;
      $display("FAIL drop_acc_ecg: wEn=%b addr=%h data=%h required 1 803 00000020", wen1, addr1, data1);
    end
    @(negedge clock);
    emg_in = 32'h0000_0030; ecg_in = 32'h0000_0040;
    wait_wen(1'b1, 60, n);
    enable1 = 1'b0;
    vectors++;
    if (wen1 !== 1'b1 || n != 38 || addr1 !== 12'hC82 || data1 !== 32'h0000_0030) begin
      errors++;
      $display("FAIL drop_wr_emg: wEn=%b n=%0d addr=%h data=%h required 1 38 C82 00000030", wen1, n, addr1, data1);
    end
    @(negedge clock);
    vectors++;
    if (wen1 !== 1'b1 || addr1 !== 12'h804 || data1 !== 32'h0000_0040) begin
      errors++;
      $display("FAIL drop_wr_ecg: wEn=%b addr=%h data=%h required 1 804 00000040", wen1, addr1, data1);
    end
    @(negedge clock);
    vectors++;
    if (wen1 !== 1'b0 || emg_idx1 !== 10'd4 || ecg_idx1 !== 10'd4) begin
      errors++;
      $display("FAIL drop_wr_idx: wEn=%b idx=%0d/%0d required 0 4/4", wen1, emg_idx1, ecg_idx1);
    end
    writes = 0;
    repeat (50) begin
      @(negedge clock);
      if (wen1 === 1'b1) writes++;
    end
    vectors++;
    if (writes != 0) begin
      errors++;
      $display("FAIL drop_wr_idle: %0d writes while disabled, required 0", writes);
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    emg_in  = 32'h0000_0077;
    enable0 = 1'b1;
    wait_wen(1'b0, 40, n);
    vectors++;
    if (wen0 !== 1'b1 || addr0 !== 12'hFFF) begin
      errors++;
      $display("FAIL rstw_emg: wEn=%b addr=%h after %0d cycles, required 1 FFF", wen0, addr0, n);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (wen0 !== 1'b0) begin
      errors++;
      $display("FAIL rstw_async_drop: wEn=%b, required 0", wen0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    enable0 = 1'b0;
    @(negedge clock);
    vectors++;
    if (wen0 !== 1'b0 || emg_idx0 !== 10'd0 || ecg_idx0 !== 10'd0 || fd0 !== 1'b0 ||
        emg_idx1 !== 10'd0 || ecg_idx1 !== 10'd0) begin
      errors++;
      $display("FAIL rstw_after: wEn=%b idx=%0d/%0d fd=%b idx1=%0d/%0d required all zero",
               wen0, emg_idx0, ecg_idx0, fd0, emg_idx1, ecg_idx1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_wrap_modulo();
    test_averaging();
    test_enable_drop();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
